// File: rtl/alu_display_pkg.sv
// rtl/alu_display_pkg.sv - display codes, segment patterns and digit helpers
// Purpose: shared constants for the divider result display.
//   4-bit display codes: 0..9 are decimal digits, 10..13 are the special glyphs.
//   SEG_* are active-low {g,f,e,d,c,b,a} patterns.
// Ports: none (package).
package alu_display_pkg;

    localparam logic [15:0] REFRESH_DIV_DEFAULT = 16'd50000;

    localparam logic [3:0] CODE_E     = 4'd10;
    localparam logic [3:0] CODE_R     = 4'd11;
    localparam logic [3:0] CODE_DASH  = 4'd12;
    localparam logic [3:0] CODE_BLANK = 4'd13;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_R     = 7'h2F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Inputs are 0..15, so the tens digit is only ever 0 or 1 and a
    // compare replaces a real divider.
    function automatic logic [3:0] tens_of(input logic [3:0] x);
        return (x >= 4'd10) ? 4'd1 : 4'd0;
    endfunction

    function automatic logic [3:0] ones_of(input logic [3:0] x);
        return (x >= 4'd10) ? (x - 4'd10) : x;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - display code to active-low 7-segment pattern
// Purpose: combinational decode of a 4-bit display code.
// Ports:
//   code  in  4  display code (0..9 digits, CODE_E/R/DASH/BLANK glyphs)
//   seg   out 7  {g,f,e,d,c,b,a}, active-low; unused codes show blank
module seg7_decoder
    import alu_display_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (code)
            4'd0:       seg = SEG_0;
            4'd1:       seg = SEG_1;
            4'd2:       seg = SEG_2;
            4'd3:       seg = SEG_3;
            4'd4:       seg = SEG_4;
            4'd5:       seg = SEG_5;
            4'd6:       seg = SEG_6;
            4'd7:       seg = SEG_7;
            4'd8:       seg = SEG_8;
            4'd9:       seg = SEG_9;
            CODE_E:     seg = SEG_E;
            CODE_R:     seg = SEG_R;
            CODE_DASH:  seg = SEG_DASH;
            default:    seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/div_result_display.sv
// rtl/div_result_display.sv - registered divider result capture and 4-digit display scan
// Purpose: latches quotient/remainder/valid on capture and scans "QQ.RR",
//   "Err " or "----" onto a time-multiplexed active-low 7-segment display.
// Ports:
//   clk          in   1  system clock, rising edge
//   rst          in   1  synchronous active-high reset
//   quotient     in   4  divider quotient
//   remainder    in   4  divider remainder
//   valid        in   1  divider valid, 0 = divide-by-zero
//   capture      in   1  latch strobe
//   seg          out  7  {g,f,e,d,c,b,a}, active-low, registered
//   dp           out  1  decimal point, active-low, registered
//   an           out  4  one-hot active-low digit enable, an[3] leftmost
//   shown_valid  out  1  valid flag of the displayed result
module div_result_display
    import alu_display_pkg::*;
#(
    parameter logic [15:0] REFRESH_DIV = REFRESH_DIV_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] quotient,
    input  logic [3:0] remainder,
    input  logic       valid,
    input  logic       capture,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       shown_valid
);

    logic [15:0] cnt;
    logic [1:0]  idx;
    logic [3:0]  q_r;
    logic [3:0]  r_r;
    logic        v_r;
    logic        loaded;

    logic [3:0]  digit_code;
    logic        digit_dp;
    logic [6:0]  digit_seg;

    // Digit content is chosen from the registers as they stand before this
    // edge, so a capture shows up one edge later and never mixes within a digit.
    always_comb begin
        digit_code = CODE_DASH;
        digit_dp   = 1'b1;
        if (loaded && !v_r) begin
            case (idx)
                2'd3:    digit_code = CODE_E;
                2'd2:    digit_code = CODE_R;
                2'd1:    digit_code = CODE_R;
                default: digit_code = CODE_BLANK;
            endcase
        end else if (loaded) begin
            case (idx)
                2'd3: digit_code = (tens_of(q_r) == 4'd0) ? CODE_BLANK : tens_of(q_r);
                2'd2: begin
                    digit_code = ones_of(q_r);
                    digit_dp   = 1'b0;
                end
                2'd1: digit_code = (tens_of(r_r) == 4'd0) ? CODE_BLANK : tens_of(r_r);
                default: digit_code = ones_of(r_r);
            endcase
        end
    end

    seg7_decoder u_seg7_decoder (
        .code (digit_code),
        .seg  (digit_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= 16'd0;
            idx    <= 2'd0;
            q_r    <= 4'd0;
            r_r    <= 4'd0;
            v_r    <= 1'b0;
            loaded <= 1'b0;
            seg    <= SEG_BLANK;
            dp     <= 1'b1;
            an     <= 4'hF;
        end else begin
            if (capture) begin
                q_r    <= quotient;
                r_r    <= remainder;
                v_r    <= valid;
                loaded <= 1'b1;
            end
            if (cnt == REFRESH_DIV - 16'd1) begin
                cnt <= 16'd0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + 16'd1;
            end
            seg <= digit_seg;
            dp  <= digit_dp;
            an  <= ~(4'b0001 << idx);
        end
    end

    // v_r is already a register loaded on the capture edge and cleared by reset.
    assign shown_valid = v_r;

endmodule
